// File: rtl/eda_region_sched.sv
// eda_region_sched: controller that walks an image for regional-max labelling.
// It either seeds a new region from the raster iterator or extends the current
// region by popping one neighbour FIFO. When the image is finished or the
// traversal is abandoned, it clears the label RAM for CLEAR_CYCLES cycles.
//
// Ports
//   clk, reset_n              : clock; asynchronous active-low reset
//   start, abort              : traversal control
//   iterated_all              : raster iterator has run out of pixels
//   fifo_empty/push_positions : per-FIFO empty flags and this cycle's pushes
//   data_out                  : FIFO head addresses, FIFO k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   next_row/next_col         : next raster pixel
//   new_pixel, read_en, update_strb, pre_center_addr : combinational issue outputs
//   center_addr               : registered copy of the last issued address
//   clear, busy, done         : decoded from the registered state
//   region_cnt                : regions seeded in the current image (saturates)

// One lane per FIFO. A lane passes its head address only while it is granted,
// so the grant mux reduces to an OR across all lanes.
module eda_region_sched_lane #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  sel,
  input  logic [ADDR_WIDTH-1:0] head,
  output logic [ADDR_WIDTH-1:0] head_gated
);
  assign head_gated = {ADDR_WIDTH{sel}} & head;
endmodule

module eda_region_sched #(
  parameter int I_WIDTH      = 8,
  parameter int J_WIDTH      = 8,
  parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH,
  parameter int NUM_FIFO     = 8,
  parameter int ARB_MODE     = 0,
  parameter int CLEAR_CYCLES = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         iterated_all,
  input  logic [NUM_FIFO-1:0]          fifo_empty,
  input  logic [NUM_FIFO-1:0]          push_positions,
  input  logic [NUM_FIFO*ADDR_WIDTH-1:0] data_out,
  input  logic [I_WIDTH-1:0]           next_row,
  input  logic [J_WIDTH-1:0]           next_col,
  output logic                         new_pixel,
  output logic [NUM_FIFO-1:0]          read_en,
  output logic                         update_strb,
  output logic [ADDR_WIDTH-1:0]        pre_center_addr,
  output logic [ADDR_WIDTH-1:0]        center_addr,
  output logic                         clear,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_WIDTH-1:0]         region_cnt
);
  localparam int PTR_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR, S_DONE} state_t;

  state_t                              state, state_nxt;
  logic                                ret_done, ret_done_nxt;  // leave CLEAR to DONE (1) or IDLE (0)
  logic [CLR_W-1:0]                    clr_cnt, clr_cnt_nxt;
  logic [PTR_W-1:0]                    rr_ptr;
  logic [PTR_W-1:0]                    grant;
  logic [NUM_FIFO-1:0]                 grant_oh;
  logic [NUM_FIFO-1:0][ADDR_WIDTH-1:0] heads, heads_gated;
  logic [ADDR_WIDTH-1:0]               head_sel;
  logic                                check_next, any_avail, run_ok, seed, extend, cnt_clr;

  assign heads = data_out;

  // The grant is only used when at least one FIFO is non-empty.
  // In both loops the last write wins. Walking the offsets downward leaves
  // the nearest FIFO at or above rr_ptr as the final winner.
  always_comb begin
    grant = '0;
    if (ARB_MODE == 0) begin
      for (int k = 0; k < NUM_FIFO; k++)
        if (!fifo_empty[k]) grant = PTR_W'(k);
    end else begin
      for (int off = NUM_FIFO - 1; off >= 0; off--)
        if (!fifo_empty[(int'(rr_ptr) + off) % NUM_FIFO])
          grant = PTR_W'((int'(rr_ptr) + off) % NUM_FIFO);
    end
    grant_oh        = '0;
    grant_oh[grant] = 1'b1;
  end

  assign check_next = (push_positions == '0) && (&fifo_empty);
  assign any_avail  = ~&fifo_empty;
  // abort and iterated_all take priority over issuing a pixel in the same cycle
  assign run_ok     = (state == S_RUN) && !abort && !iterated_all;
  assign seed       = run_ok && check_next;
  // With pushes in flight and every FIFO empty, neither case applies: the cycle is a bubble
  assign extend     = run_ok && !check_next && any_avail;

  assign read_en     = extend ? grant_oh : '0;
  assign new_pixel   = seed | extend;
  assign update_strb = seed;

  for (genvar k = 0; k < NUM_FIFO; k++) begin : g_lane
    eda_region_sched_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .sel        (read_en[k]),
      .head       (heads[k]),
      .head_gated (heads_gated[k])
    );
  end

  always_comb begin
    head_sel = '0;
    for (int k = 0; k < NUM_FIFO; k++) head_sel |= heads_gated[k];
  end

  // head_sel is already zero unless this is an extend cycle
  assign pre_center_addr = seed ? {next_row, next_col} : head_sel;

  always_comb begin
    state_nxt    = state;
    ret_done_nxt = ret_done;
    clr_cnt_nxt  = clr_cnt;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (abort) begin
          state_nxt = S_CLEAR; ret_done_nxt = 1'b0; clr_cnt_nxt = '0;
        end else if (iterated_all) begin
          state_nxt = S_CLEAR; ret_done_nxt = 1'b1; clr_cnt_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
          state_nxt   = ret_done ? S_DONE : S_IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (start)      state_nxt = S_RUN;
        else if (abort) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cnt_clr = ((state == S_IDLE) || (state == S_DONE)) && start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ret_done    <= 1'b0;
      clr_cnt     <= '0;
      rr_ptr      <= '0;
      center_addr <= '0;
      region_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      ret_done <= ret_done_nxt;
      clr_cnt  <= clr_cnt_nxt;
      if (new_pixel) center_addr <= pre_center_addr;
      if (cnt_clr)                        region_cnt <= '0;
      else if (seed && region_cnt != '1)  region_cnt <= region_cnt + 1'b1;
      if (ARB_MODE != 0 && extend)
        rr_ptr <= (grant == PTR_W'(NUM_FIFO - 1)) ? '0 : grant + 1'b1;
    end
  end

  assign clear = (state == S_CLEAR);
  assign busy  = (state == S_RUN) || (state == S_CLEAR);
  assign done  = (state == S_DONE);
endmodule

// File: doc/eda_region_sched.md
Name: eda_region_sched

Overview:
- Next-generation regional-max traversal controller. Sequences raster-order pixel fetch and neighbour-FIFO extension for the flood-fill datapath.
- Generalised to NUM_FIFO neighbour FIFOs with per-FIFO data buses.
- Adds selectable fixed or round-robin FIFO arbitration, abort, multi-cycle RAM clear, push-pending bubbles and a region counter.
- Sits between the raster iterator/neighbour FIFOs and the window/label RAM datapath.

Parameters:
- I_WIDTH, 8, row index width.
- J_WIDTH, 8, column index width.
- ADDR_WIDTH, I_WIDTH+J_WIDTH, pixel address width.
- NUM_FIFO, 8, number of neighbour FIFOs (window width minus 1).
- ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.
- CLEAR_CYCLES, 4, cycles clear is held; must be >=1.
- CNT_WIDTH, 16, region counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- start  in  1  start a traversal; sampled in IDLE/DONE.
- abort  in  1  abandon the current traversal.
- iterated_all  in  1  raster iterator exhausted.
- fifo_empty  in  NUM_FIFO  per-FIFO empty flags.
- push_positions  in  NUM_FIFO  FIFOs being pushed this cycle.
- data_out  in  NUM_FIFO*ADDR_WIDTH  FIFO head addresses; FIFO k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- next_row  in  I_WIDTH  next raster row.
- next_col  in  J_WIDTH  next raster column.
- new_pixel  out  1  pixel issued this cycle.
- read_en  out  NUM_FIFO  one-hot FIFO pop.
- update_strb  out  1  new region seed issued this cycle.
- pre_center_addr  out  ADDR_WIDTH  combinational next centre address.
- center_addr  out  ADDR_WIDTH  registered centre address.
- clear  out  1  RAM clear.
- busy  out  1  state is RUN or CLEAR.
- done  out  1  image complete.
- region_cnt  out  CNT_WIDTH  regions seeded in current image.

Behaviour:
- Reset: state IDLE. center_addr=0, region_cnt=0, rr_ptr=0, clr_cnt=0. All outputs 0.
- States: IDLE, RUN, CLEAR, DONE. Internal ret register selects the state after CLEAR (IDLE or DONE).
- Internal terms:
  - check_next = (push_positions==0) & (&fifo_empty).
  - any_avail = ~&fifo_empty.
- IDLE: start -> RUN and region_cnt<=0. Otherwise stay. No strobes.
- RUN, priority abort > iterated_all > issue:
  - abort: -> CLEAR, ret=IDLE. No strobes this cycle.
  - iterated_all: -> CLEAR, ret=DONE. No strobes this cycle.
  - check_next (seed): new_pixel=1, update_strb=1, pre_center_addr={next_row,next_col}. region_cnt+1, saturating at all-ones.
  - else any_avail (extend): new_pixel=1, read_en=grant, pre_center_addr=data_out slice of grant, update_strb=0.
  - else (pushes pending, all FIFOs empty): bubble. new_pixel=0, read_en=0, pre_center_addr=0, no state change.
  - start in RUN is ignored.
- Arbitration:
  - ARB_MODE 0: grant = highest-index non-empty FIFO.
  - ARB_MODE 1: grant = first non-empty FIFO at or above rr_ptr, searching upward with wrap. After each pop, rr_ptr <= (grant+1) mod NUM_FIFO.
  - read_en is never asserted for an empty FIFO and is at most one-hot.
- center_addr: loads pre_center_addr on the cycle after any seed or extend. Otherwise holds. pre_center_addr=0 when no strobe.
- CLEAR: clear=1 for exactly CLEAR_CYCLES consecutive cycles (clr_cnt counts 0..CLEAR_CYCLES-1), then -> ret. Inputs are ignored. region_cnt holds so it is readable in DONE.
- DONE: done=1. start -> RUN with region_cnt<=0; abort -> IDLE; start and abort together -> RUN.
- busy=1 in RUN and CLEAR.
- new_pixel, read_en, update_strb and pre_center_addr are combinational from state and inputs. clear, done and busy are decoded from registered state only.
- Reset mid-operation: immediate return to reset values; any partially run clear is not completed.

Test Plan:
- Reset, start, with fifo_empty=all-1, push_positions=0, next_row=3, next_col=5 -> next cycle update_strb=1, new_pixel=1, pre_center_addr=0x0305; following cycle center_addr=0x0305, region_cnt=1.
- ARB_MODE 0, fifo_empty=8'b1110_1011, heads 0x0011 (FIFO 2) and 0x0044 (FIFO 4) -> read_en=8'b0001_0000, pre_center_addr=0x0044; after FIFO 4 empties, read_en=8'b0000_0100.
- ARB_MODE 1, FIFOs 1, 3 and 6 non-empty continuously, rr_ptr=0 -> grants 1, 3, 6, 1 on successive cycles.
- push_positions=8'h01 with all FIFOs empty -> new_pixel=0, read_en=0 for that cycle; next cycle FIFO 0 non-empty -> pop of FIFO 0.
- iterated_all pulse in RUN -> clear high for exactly CLEAR_CYCLES=4 cycles, busy high throughout, then done=1 with region_cnt held; start -> RUN, region_cnt=0.
- abort in RUN during an extend -> no read_en that cycle, 4 clear cycles, then IDLE with done=0; reset_n low mid-CLEAR -> clear=0 immediately, state IDLE.
